// File: rtl/shadow_ret_stack_pkg.sv
// Shared types and constants for the shadow return-address stack.
package shadow_ret_stack_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE      = 2'd0,
    CAUSE_MISMATCH  = 2'd1,
    CAUSE_UNDERFLOW = 2'd2,
    CAUSE_OVERFLOW  = 2'd3
  } shstk_cause_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_SCRUB = 2'd2
  } shstk_state_e;

  localparam logic [31:0] SHSTK_DEFAULT_KEY = 32'h73fa06c2;

endpackage

// File: rtl/shadow_ret_stack_shstk_mem.sv
// DEPTH x VLEN entry file: one write port, async read of the entry below ptr_i.
// Build option SHADOW_RET_STACK_MASK_EN stores entries XORed with MASK_KEY.
module shstk_mem
  import shadow_ret_stack_pkg::*;
#(
  parameter int unsigned VLEN     = 32,
  parameter int unsigned DEPTH    = 16,
  parameter logic [31:0] MASK_KEY = SHSTK_DEFAULT_KEY
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [VLEN-1:0]          wdata_i,
  input  logic [$clog2(DEPTH)-1:0] ptr_i,
  output logic [VLEN-1:0]          rdata_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [VLEN-1:0] KEY_FULL = VLEN'(MASK_KEY);
`ifdef SHADOW_RET_STACK_MASK_EN
  localparam logic [VLEN-1:0] KEY = KEY_FULL;
`else
  localparam logic [VLEN-1:0] KEY = KEY_FULL & {VLEN{1'b0}};
`endif

  logic [VLEN-1:0] mem_q [DEPTH];

  // Entry storage; contents are deliberately not reset (count gates validity).
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i ^ KEY;
    end
  end

  assign rdata_o = mem_q[ptr_i - PW'(1)] ^ KEY;

endmodule

// File: rtl/shadow_ret_stack.sv
// Shadow return-address stack: checks committed returns against recorded calls.
// Optional build macro: SHADOW_RET_STACK_MASK_EN (XOR-masked entry storage).
module shadow_ret_stack
  import shadow_ret_stack_pkg::*;
#(
  parameter int unsigned VLEN     = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned OVF_MODE = 0,
  parameter logic [31:0] MASK_KEY = SHSTK_DEFAULT_KEY
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     commit_valid_i,
  output logic                     ready_o,
  input  logic                     is_call_i,
  input  logic                     is_ret_i,
  input  logic [VLEN-1:0]          link_addr_i,
  input  logic [VLEN-1:0]          target_i,
  input  logic                     flush_i,
  input  logic                     clear_i,
  output logic                     crash_o,
  output logic                     violation_o,
  output logic [1:0]               viol_cause_o,
  output logic [VLEN-1:0]          viol_addr_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0]   FULL     = CW'(DEPTH);
  localparam logic [VLEN-1:0] CMP_MASK = {{(VLEN-1){1'b1}}, 1'b0};

  shstk_state_e    state_q, state_d;
  shstk_cause_e    cause_q, cause_d, cause_new_s;
  logic [PW-1:0]   ptr_q, ptr_d, scrub_q, scrub_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            lost_q, lost_d, crash_q, crash_d, viol_q, viol_d;
  logic [VLEN-1:0] vaddr_q, vaddr_d, addr_new_s;
  logic            we_s, raise_s, empty_s, full_s, mism_s, underflow_s;
  logic [PW-1:0]   waddr_s;
  logic [VLEN-1:0] wdata_s, top_s;

  shstk_mem #(.VLEN(VLEN), .DEPTH(DEPTH), .MASK_KEY(MASK_KEY)) u_mem (
    .clk_i   (clk_i),
    .we_i    (we_s),
    .waddr_i (waddr_s),
    .wdata_i (wdata_s),
    .ptr_i   (ptr_q),
    .rdata_o (top_s)
  );

  assign empty_s     = (cnt_q == '0);
  assign full_s      = (cnt_q == FULL);
  assign mism_s      = |((top_s ^ target_i) & CMP_MASK);
  // With wrap mode, an empty stack after lost entries cannot prove an attack.
  assign underflow_s = empty_s && !((OVF_MODE == 32'd0) && lost_q);

  // Next-state, stack update and violation capture.
  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    lost_d      = lost_q;
    scrub_d     = scrub_q;
    viol_d      = viol_q;
    vaddr_d     = vaddr_q;
    crash_d     = 1'b0;
    we_s        = 1'b0;
    waddr_s     = ptr_q;
    wdata_s     = link_addr_i;
    raise_s     = 1'b0;
    cause_new_s = CAUSE_NONE;
    addr_new_s  = target_i;
    case (state_q)
      ST_RUN: begin
        if (commit_valid_i) begin
          case ({is_call_i, is_ret_i})
            2'b10: begin
              if (full_s && (OVF_MODE == 32'd1)) begin
                raise_s     = 1'b1;
                cause_new_s = CAUSE_OVERFLOW;
                addr_new_s  = link_addr_i;
              end else begin
                we_s  = 1'b1;
                ptr_d = ptr_q + PW'(1);
                if (full_s) begin
                  lost_d = 1'b1;
                end else begin
                  cnt_d = cnt_q + CW'(1);
                end
              end
            end
            2'b01: begin
              if (empty_s) begin
                raise_s     = underflow_s;
                cause_new_s = CAUSE_UNDERFLOW;
              end else begin
                raise_s     = mism_s;
                cause_new_s = CAUSE_MISMATCH;
                ptr_d       = ptr_q - PW'(1);
                cnt_d       = cnt_q - CW'(1);
              end
            end
            2'b11: begin
              we_s = 1'b1;
              if (empty_s) begin
                raise_s     = underflow_s;
                cause_new_s = CAUSE_UNDERFLOW;
                ptr_d       = ptr_q + PW'(1);
                cnt_d       = cnt_q + CW'(1);
              end else begin
                raise_s     = mism_s;
                cause_new_s = CAUSE_MISMATCH;
                waddr_s     = ptr_q - PW'(1);
              end
            end
            default: begin
              raise_s = 1'b0;
            end
          endcase
          if (raise_s && en_i) begin
            state_d = ST_HALT;
            crash_d = 1'b1;
            viol_d  = 1'b1;
            cause_d = cause_new_s;
            vaddr_d = addr_new_s;
          end else begin
            crash_d = 1'b0;
          end
        end else begin
          crash_d = 1'b0;
        end
      end
      ST_HALT: begin
        if (clear_i) begin
          state_d = ST_RUN;
          viol_d  = 1'b0;
          cause_d = CAUSE_NONE;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_SCRUB: begin
        we_s    = 1'b1;
        waddr_s = scrub_q;
        wdata_s = '0;
        scrub_d = scrub_q + PW'(1);
        if (scrub_q == PW'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_SCRUB;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    // Flush overrides everything, including a simultaneous clear or violation.
    if (flush_i) begin
      state_d = ST_SCRUB;
      ptr_d   = '0;
      cnt_d   = '0;
      lost_d  = 1'b0;
      scrub_d = '0;
      viol_d  = 1'b0;
      cause_d = CAUSE_NONE;
      crash_d = 1'b0;
    end else begin
      lost_d = lost_d;
    end
  end

  // State and status registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      cause_q <= CAUSE_NONE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      lost_q  <= 1'b0;
      scrub_q <= '0;
      crash_q <= 1'b0;
      viol_q  <= 1'b0;
      vaddr_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      lost_q  <= lost_d;
      scrub_q <= scrub_d;
      crash_q <= crash_d;
      viol_q  <= viol_d;
      vaddr_q <= vaddr_d;
    end
  end

  assign ready_o      = (state_q != ST_SCRUB);
  assign crash_o      = crash_q;
  assign violation_o  = viol_q;
  assign viol_cause_o = cause_q;
  assign viol_addr_o  = vaddr_q;
  assign count_o      = cnt_q;

endmodule

// File: tb/tb_shadow_ret_stack.sv
// Directed, table-driven bench for shadow_ret_stack (DEPTH=16 wrap, DEPTH=4 overflow).
module tb_shadow_ret_stack;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        cv, ca, re, en, fl, clr;
  logic [31:0] link, tgt;
  logic        rdy, crash, viol;
  logic [1:0]  cause;
  logic [31:0] vaddr;
  logic [4:0]  cnt;

  logic        ocv, oca, ore, oen, ofl, oclr;
  logic [31:0] olink, otgt;
  logic        ordy, ocrash, oviol;
  logic [1:0]  ocause;
  logic [31:0] ovaddr;
  logic [2:0]  ocnt;

  shadow_ret_stack #(.VLEN(32), .DEPTH(16), .OVF_MODE(0)) u_dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .commit_valid_i(cv), .ready_o(rdy),
    .is_call_i(ca), .is_ret_i(re), .link_addr_i(link), .target_i(tgt),
    .flush_i(fl), .clear_i(clr), .crash_o(crash), .violation_o(viol),
    .viol_cause_o(cause), .viol_addr_o(vaddr), .count_o(cnt)
  );

  shadow_ret_stack #(.VLEN(32), .DEPTH(4), .OVF_MODE(1)) u_ovf (
    .clk_i(clk), .rst_i(rst), .en_i(oen), .commit_valid_i(ocv), .ready_o(ordy),
    .is_call_i(oca), .is_ret_i(ore), .link_addr_i(olink), .target_i(otgt),
    .flush_i(ofl), .clear_i(oclr), .crash_o(ocrash), .violation_o(oviol),
    .viol_cause_o(ocause), .viol_addr_o(ovaddr), .count_o(ocnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        cv, ca, re, en, clr;
    logic [31:0] link, tgt;
    logic        crash, viol;
    logic [1:0]  cause;
    logic [4:0]  cnt;
    logic [31:0] vaddr;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t v(input logic c, a, r, e, cl, input logic [31:0] l, t,
                             input logic xc, xv, input logic [1:0] xca,
                             input logic [4:0] xn, input logic [31:0] xa);
    vec_t x;
    x.cv = c; x.ca = a; x.re = r; x.en = e; x.clr = cl; x.link = l; x.tgt = t;
    x.crash = xc; x.viol = xv; x.cause = xca; x.cnt = xn; x.vaddr = xa;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic c, a, r, e, f, cl, input logic [31:0] l, t);
    @(negedge clk);
    cv = c; ca = a; re = r; en = e; fl = f; clr = cl; link = l; tgt = t;
    @(posedge clk);
    #1;
  endtask

  task automatic ocyc(input logic c, a, r, cl, input logic [31:0] l, t);
    @(negedge clk);
    ocv = c; oca = a; ore = r; oclr = cl; olink = l; otgt = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    //            cv    ca    re    en    clr   link      tgt        crash viol  cause  cnt   vaddr
    tbl[0]  = v(1'b1,1'b1,1'b0,1'b1,1'b0,32'h100,32'h0,   1'b0,1'b0,2'd0,5'd1,32'h0);
    tbl[1]  = v(1'b1,1'b1,1'b0,1'b1,1'b0,32'h200,32'h0,   1'b0,1'b0,2'd0,5'd2,32'h0);
    tbl[2]  = v(1'b1,1'b1,1'b0,1'b1,1'b0,32'h300,32'h0,   1'b0,1'b0,2'd0,5'd3,32'h0);
    tbl[3]  = v(1'b1,1'b0,1'b1,1'b1,1'b0,32'h0,  32'h300, 1'b0,1'b0,2'd0,5'd2,32'h0);
    tbl[4]  = v(1'b1,1'b0,1'b1,1'b1,1'b0,32'h0,  32'h200, 1'b0,1'b0,2'd0,5'd1,32'h0);
    tbl[5]  = v(1'b1,1'b0,1'b1,1'b1,1'b0,32'h0,  32'h101, 1'b0,1'b0,2'd0,5'd0,32'h0);
    tbl[6]  = v(1'b1,1'b0,1'b1,1'b1,1'b0,32'h0,  32'h500, 1'b1,1'b1,2'd2,5'd0,32'h500);
    tbl[7]  = v(1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,  32'h0,   1'b0,1'b1,2'd2,5'd0,32'h500);
    tbl[8]  = v(1'b1,1'b1,1'b0,1'b1,1'b0,32'h700,32'h0,   1'b0,1'b1,2'd2,5'd0,32'h500);
    tbl[9]  = v(1'b0,1'b0,1'b0,1'b1,1'b1,32'h0,  32'h0,   1'b0,1'b0,2'd0,5'd0,32'h500);
    tbl[10] = v(1'b1,1'b1,1'b0,1'b1,1'b0,32'h100,32'h0,   1'b0,1'b0,2'd0,5'd1,32'h500);
    tbl[11] = v(1'b1,1'b0,1'b1,1'b1,1'b0,32'h0,  32'h104, 1'b1,1'b1,2'd1,5'd0,32'h104);
    tbl[12] = v(1'b0,1'b0,1'b0,1'b1,1'b1,32'h0,  32'h0,   1'b0,1'b0,2'd0,5'd0,32'h104);
    tbl[13] = v(1'b1,1'b1,1'b0,1'b0,1'b0,32'h100,32'h0,   1'b0,1'b0,2'd0,5'd1,32'h104);
    tbl[14] = v(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,  32'h999, 1'b0,1'b0,2'd0,5'd0,32'h104);
    tbl[15] = v(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,  32'h0,   1'b0,1'b0,2'd0,5'd0,32'h104);
    tbl[16] = v(1'b1,1'b1,1'b0,1'b1,1'b0,32'h400,32'h0,   1'b0,1'b0,2'd0,5'd1,32'h104);
    tbl[17] = v(1'b1,1'b1,1'b1,1'b1,1'b0,32'h800,32'h400, 1'b0,1'b0,2'd0,5'd1,32'h104);
    tbl[18] = v(1'b1,1'b0,1'b1,1'b1,1'b0,32'h0,  32'h800, 1'b0,1'b0,2'd0,5'd0,32'h104);
    tbl[19] = v(1'b1,1'b1,1'b1,1'b1,1'b0,32'ha00,32'h900, 1'b1,1'b1,2'd2,5'd1,32'h900);
    tbl[20] = v(1'b0,1'b0,1'b0,1'b1,1'b1,32'h0,  32'h0,   1'b0,1'b0,2'd0,5'd1,32'h900);
    tbl[21] = v(1'b1,1'b0,1'b1,1'b1,1'b0,32'h0,  32'ha00, 1'b0,1'b0,2'd0,5'd0,32'h900);

    cv = 1'b0; ca = 1'b0; re = 1'b0; en = 1'b1; fl = 1'b0; clr = 1'b0; link = '0; tgt = '0;
    ocv = 1'b0; oca = 1'b0; ore = 1'b0; oen = 1'b1; ofl = 1'b0; oclr = 1'b0; olink = '0; otgt = '0;
    rst = 1'b1;
    #22;
    chk("rst crash", 32'(crash), 32'd0);
    chk("rst viol", 32'(viol), 32'd0);
    chk("rst cause", 32'(cause), 32'd0);
    chk("rst count", 32'(cnt), 32'd0);
    chk("rst addr", vaddr, 32'd0);
    chk("rst ready", 32'(rdy), 32'd1);
    chk("rst ovf ready", 32'(ordy), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      cyc(tbl[i].cv, tbl[i].ca, tbl[i].re, tbl[i].en, 1'b0, tbl[i].clr, tbl[i].link, tbl[i].tgt);
      chk($sformatf("v%0d crash", i), 32'(crash), 32'(tbl[i].crash));
      chk($sformatf("v%0d viol", i), 32'(viol), 32'(tbl[i].viol));
      chk($sformatf("v%0d cause", i), 32'(cause), 32'(tbl[i].cause));
      chk($sformatf("v%0d count", i), 32'(cnt), 32'(tbl[i].cnt));
      chk($sformatf("v%0d addr", i), vaddr, tbl[i].vaddr);
      chk($sformatf("v%0d ready", i), 32'(rdy), 32'd1);
    end

    // Flush with three entries; a simultaneous push must lose to the flush.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40 + 32'(i), 32'h0);
    chk("pre-flush count", 32'(cnt), 32'd3);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hb00, 32'h0);
    chk("flush count", 32'(cnt), 32'd0);
    chk("flush ready", 32'(rdy), 32'd0);
    low = 1;
    for (int k = 0; k < 40; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hc00, 32'h0);
      if (rdy) break;
      low++;
    end
    chk("scrub length", 32'(low), 32'd16);
    chk("scrub drops commits", 32'(cnt), 32'd0);

    // Wrap: 17 pushes, 16 matching returns, then a 17th return tolerated via lost.
    for (int i = 1; i <= 17; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'(i * 16), 32'h0);
    chk("wrap count", 32'(cnt), 32'd16);
    for (int i = 17; i >= 2; i--) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'(i * 16));
      chk($sformatf("wrap ret %0d crash", i), 32'(crash), 32'd0);
    end
    chk("wrap drained", 32'(cnt), 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h123);
    chk("lost ret crash", 32'(crash), 32'd0);
    chk("lost ret viol", 32'(viol), 32'd0);

    // Flush clears lost, so the next empty return is an underflow.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 16; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("post-scrub ready", 32'(rdy), 32'd1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h124);
    chk("post-flush uflow crash", 32'(crash), 32'd1);
    chk("post-flush uflow cause", 32'(cause), 32'd2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0);
    chk("flush+clear viol", 32'(viol), 32'd0);
    chk("flush+clear ready", 32'(rdy), 32'd0);
    chk("flush keeps addr", vaddr, 32'h124);

    // Asynchronous reset mid-scrub.
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("mid-scrub rst ready", 32'(rdy), 32'd1);
    chk("mid-scrub rst addr", vaddr, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset in HALT.
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h18, 32'h0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h20);
    chk("halt mism viol", 32'(viol), 32'd1);
    chk("halt mism count", 32'(cnt), 32'd1);
    #2 rst = 1'b1;
    cv = 1'b0; ca = 1'b0; re = 1'b0;
    #1;
    chk("halt rst viol", 32'(viol), 32'd0);
    chk("halt rst crash", 32'(crash), 32'd0);
    chk("halt rst cause", 32'(cause), 32'd0);
    chk("halt rst count", 32'(cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Overflow-as-violation on the DEPTH=4 instance.
    for (int i = 1; i <= 4; i++) ocyc(1'b1, 1'b1, 1'b0, 1'b0, 32'(i * 16), 32'h0);
    chk("ovf full count", 32'(ocnt), 32'd4);
    ocyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h550, 32'h0);
    chk("ovf crash", 32'(ocrash), 32'd1);
    chk("ovf cause", 32'(ocause), 32'd3);
    chk("ovf addr", ovaddr, 32'h550);
    chk("ovf count", 32'(ocnt), 32'd4);
    ocyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("ovf crash pulse", 32'(ocrash), 32'd0);
    chk("ovf viol sticky", 32'(oviol), 32'd1);
    ocyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    chk("ovf clear", 32'(oviol), 32'd0);
    for (int i = 4; i >= 1; i--) begin
      ocyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'(i * 16));
      chk($sformatf("ovf ret %0d crash", i), 32'(ocrash), 32'd0);
      chk($sformatf("ovf ret %0d count", i), 32'(ocnt), 32'(i - 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
